// File: rtl/instr_fetch.sv
// Ripple-32 instruction fetch: owns the PC, keeps one imem request in flight, buffers words for decode.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned redirect targets into a single flagged entry.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [6:0]  instr_opcode,
   output logic [31:0] instr_pc,
   output logic        instr_fault,
   output logic        instr_misaligned
);
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   out_pc_q, out_pc_d;
   logic [31:0]   redir_pc_q, redir_pc_d;
   logic          redir_pend_q, redir_pend_d;
   logic          discard_q, discard_d;
   logic          halted_q, halted_d;
   logic          mis_pend_q, mis_pend_d;
   logic [31:0]   mis_pc_q, mis_pc_d;

   logic [31:0]   fifo_instr_q [BUF_DEPTH];
   logic [31:0]   fifo_pc_q    [BUF_DEPTH];
   logic          fifo_fault_q [BUF_DEPTH];
   logic          fifo_mis_q   [BUF_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   instr_q, instr_pc_q;
   logic          instr_fault_q, instr_mis_q;

   logic          redir_mis;
   logic [31:0]   redir_tgt;
   logic          push, push_rsp, pop, issue_ok, issue_now, head_load;
   logic [31:0]   push_instr, push_pc, head_instr, head_pc;
   logic          push_fault, push_mis, head_fault, head_mis;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_mis = (redirect_pc[1:0] != 2'b00);
`else
   assign redir_mis = 1'b0;
`endif
   assign redir_tgt = {redirect_pc[31:2], 2'b00};

   assign instr_valid = (cnt_q != '0) && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   assign push_rsp    = (state_q == WAIT) && imem_rvalid && !discard_q && !redirect_valid;
   assign push        = push_rsp || (mis_pend_q && !redirect_valid);

   always_comb begin
      if (push_rsp) begin
         push_instr = imem_rdata;
         push_pc    = out_pc_q;
         push_fault = imem_err;
         push_mis   = 1'b0;
      end else begin
         push_instr = '0;
         push_pc    = mis_pc_q;
         push_fault = 1'b0;
         push_mis   = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // The output registers track the post-update head so the pushed word is visible one cycle after rvalid.
   always_comb begin
      head_load = !redirect_valid && (cnt_d != '0);
      if (push && (rd_ptr_d == wr_ptr_q)) begin
         head_instr = push_instr;
         head_pc    = push_pc;
         head_fault = push_fault;
         head_mis   = push_mis;
      end else begin
         head_instr = fifo_instr_q[rd_ptr_d];
         head_pc    = fifo_pc_q[rd_ptr_d];
         head_fault = fifo_fault_q[rd_ptr_d];
         head_mis   = fifo_mis_q[rd_ptr_d];
      end
   end

   always_comb begin
      if (redirect_valid)             halted_d = redir_mis;
      else if (push_rsp && imem_err)  halted_d = 1'b1;
      else                            halted_d = halted_q;
      mis_pend_d = redirect_valid && redir_mis;
      mis_pc_d   = redirect_valid ? redirect_pc : mis_pc_q;
   end

   // Issue is judged on post-response occupancy; the follow-on request goes out in the rvalid cycle
   // itself, which is what lets a zero-wait memory deliver one word per cycle with a single outstanding.
   assign issue_ok  = !halted_d && (cnt_d < CW'(BUF_DEPTH));
   assign issue_now = (state_q == WAIT) && imem_rvalid && !redirect_valid && issue_ok;
   assign imem_req  = (state_q == REQ) || issue_now;
   assign imem_addr = fetch_pc_q;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      out_pc_d     = out_pc_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      discard_d    = discard_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_valid) fetch_pc_d = redir_tgt;
            if (issue_ok)       state_d    = REQ;
         end
         REQ: begin
            if (imem_gnt) begin
               state_d      = WAIT;
               out_pc_d     = fetch_pc_q;
               redir_pend_d = 1'b0;
               if (redirect_valid) begin
                  fetch_pc_d = redir_tgt;
                  discard_d  = 1'b1;
               end else if (redir_pend_q) begin
                  fetch_pc_d = redir_pc_q;
                  discard_d  = 1'b1;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end else if (redirect_valid) begin
               // Address must stay stable until granted; park the target until then.
               redir_pend_d = 1'b1;
               redir_pc_d   = redir_tgt;
            end
         end
         WAIT: begin
            if (redirect_valid) fetch_pc_d = redir_tgt;
            if (imem_rvalid) begin
               discard_d = 1'b0;
               if (issue_now && imem_gnt) begin
                  out_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end else if (issue_ok) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         out_pc_q      <= '0;
         redir_pc_q    <= '0;
         redir_pend_q  <= 1'b0;
         discard_q     <= 1'b0;
         halted_q      <= 1'b0;
         mis_pend_q    <= 1'b0;
         mis_pc_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_fault_q <= 1'b0;
         instr_mis_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         out_pc_q     <= out_pc_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         discard_q    <= discard_d;
         halted_q     <= halted_d;
         mis_pend_q   <= mis_pend_d;
         mis_pc_q     <= mis_pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         if (head_load) begin
            instr_q       <= head_instr;
            instr_pc_q    <= head_pc;
            instr_fault_q <= head_fault;
            instr_mis_q   <= head_mis;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= push_instr;
         fifo_pc_q[wr_ptr_q]    <= push_pc;
         fifo_fault_q[wr_ptr_q] <= push_fault;
         fifo_mis_q[wr_ptr_q]   <= push_mis;
      end
   end

   assign instr            = instr_q;
   assign instr_opcode     = instr_q[6:0];
   assign instr_pc         = instr_pc_q;
   assign instr_fault      = instr_fault_q;
   assign instr_misaligned = instr_mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory timing against an address-stream model of what decode must see.
`timescale 1ns/1ps
module tb_instr_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_gnt, imem_rvalid, imem_err;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid, instr_valid, instr_ready;
   logic [31:0] redirect_pc, instr, instr_pc;
   logic [6:0]  instr_opcode;
   logic        instr_fault, instr_misaligned;
   logic        gnt_en;

   instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_opcode(instr_opcode), .instr_pc(instr_pc), .instr_fault(instr_fault),
      .instr_misaligned(instr_misaligned)
   );

   assign imem_gnt = imem_req & gnt_en;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Memory environment: 0 = zero-wait, 1 = fixed 4-cycle latency, 2 = random grant and latency.
   int unsigned mem_mode = 0;
   logic        err_on = 1'b0;
   logic [31:0] err_addr = 32'h10;
   logic        mem_pend = 1'b0;
   logic [31:0] mem_pend_addr = '0;
   int          mem_lat = 0;
   int          first_gnt_cyc = -1;
   logic [31:0] first_gnt_addr = '1;
   int          gnt_count = 0;
   int          proto_err = 0;
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;

   initial begin
      imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0; gnt_en = 1'b0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         imem_err    = 1'b0;
         if (!rst_n) begin
            mem_pend  = 1'b0;
            prev_wait = 1'b0;
         end else if (mem_pend) begin
            if (mem_lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_pend_addr ^ 32'hA5A5_0000;
               imem_err    = err_on && (mem_pend_addr == err_addr);
               mem_pend    = 1'b0;
            end else begin
               mem_lat--;
            end
         end
         gnt_en = (mem_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (rst_n) begin
            if (prev_wait && (!imem_req || imem_addr != prev_addr)) proto_err++;
            prev_wait = imem_req && !imem_gnt;
            prev_addr = imem_addr;
            if (imem_req && imem_gnt) begin
               if (mem_pend) proto_err++;
               if (imem_addr[1:0] != 2'b00) proto_err++;
               mem_pend      = 1'b1;
               mem_pend_addr = imem_addr;
               mem_lat       = (mem_mode == 0) ? 0 : (mem_mode == 1) ? 4 : int'($urandom_range(0, 3));
               if (first_gnt_cyc < 0) begin
                  first_gnt_cyc  = cyc;
                  first_gnt_addr = imem_addr;
               end
               gnt_count++;
            end
         end
      end
   end

   // Reference: decode sees consecutive words from the last redirect target, up to and including a faulting one.
   logic [31:0] exp_next = RST_PC;
   logic        done = 1'b0;
   logic        mis_exp = 1'b0;
   logic [31:0] mis_pc_exp = '0;
   int          pops = 0;
   logic [31:0] last_pc = '0;
   logic        saw_wrap = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      logic [31:0] w;
      if (redirect_valid) begin
         chk("valid_in_redirect", instr_valid, 0);
         done = 1'b0;
         mis_exp = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            mis_exp    = 1'b1;
            mis_pc_exp = redirect_pc;
         end
`endif
         exp_next = redirect_pc & ~32'h3;
      end else if (done) begin
         chk("halt_valid", instr_valid, 0);
         chk("halt_req", imem_req, 0);
      end else if (instr_valid && instr_ready) begin
         pops++;
         if (mis_exp) begin
            chk("mis_pc", instr_pc, mis_pc_exp);
            chk("mis_instr", instr, 0);
            chk("mis_fault", instr_fault, 0);
            chk("mis_flag", instr_misaligned, 1);
            mis_exp = 1'b0;
            done    = 1'b1;
         end else begin
            w = exp_next ^ 32'hA5A5_0000;
            chk("pc", instr_pc, exp_next);
            chk("instr", instr, w);
            chk("opcode", instr_opcode, {25'd0, w[6:0]});
            chk("fault", instr_fault, err_on && (exp_next == err_addr));
            chk("misaligned", instr_misaligned, 0);
            if (last_pc == 32'hFFFF_FFFC && exp_next == 32'h0) saw_wrap = 1'b1;
            last_pc = exp_next;
            if (err_on && (exp_next == err_addr)) done = 1'b1;
            exp_next = exp_next + 32'd4;
         end
      end
   endtask

   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      redirect_valid = rv;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      #2;
      model_check();
   endtask

   initial begin
      int first_valid_cyc;
      int vcnt, scnt, mark, g0;
      logic found;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      first_valid_cyc = -1;

      repeat (3) @(negedge clk);
      #2;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_opcode", instr_opcode, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_fault", instr_fault, 0);
      chk("rst_mis", instr_misaligned, 0);
      #1 rst_n = 1'b1;

      // Zero-wait streaming from reset.
      vcnt = 0; scnt = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, '0, 1'b1);
         if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (first_valid_cyc >= 0) begin
            scnt++;
            if (instr_valid) vcnt++;
         end
      end
      chk("first_addr", first_gnt_addr, RST_PC);
      chk("first_latency", first_valid_cyc - first_gnt_cyc, 2);
      chk("throughput", vcnt, scnt);

      // Decode stall.
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
      chk("stall_req", imem_req, 0);
      chk("stall_valid", instr_valid, 1);
      chk("stall_head", instr_pc, exp_next);
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

      // Redirect while waiting on the 0x8 response.
      mem_mode = 1;
      step(1'b1, 32'h0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step(1'b0, '0, 1'b1);
         if (mem_pend && mem_pend_addr == 32'h8 && mem_lat >= 1) found = 1'b1;
      end
      chk("wait_on_8", found, 1);
      step(1'b1, 32'h100, 1'b1);
      mark = pops;
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);
      chk("redir_progress", (pops - mark) >= 3, 1);

      // Bus error at 0x10 halts fetch until a redirect.
      mem_mode = 2;
      err_on   = 1'b1;
      step(1'b1, 32'h0, 1'b1);
      for (int i = 0; i < 300 && !done; i++) step(1'b0, '0, 1'b1);
      chk("fault_reached", done, 1);
      g0 = gnt_count;
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      chk("halt_no_grant", gnt_count - g0, 0);
      step(1'b1, 32'h40, 1'b1);
      mark = pops;
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);
      chk("resume_progress", (pops - mark) >= 3, 1);

      // PC wraps past the top of the address space.
      step(1'b1, 32'hFFFF_FFF0, 1'b1);
      for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b1);
      chk("pc_wrap", saw_wrap, 1);

      // Random ready, random redirects, random memory timing.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0)
            step(1'b1, ($urandom_range(0, 63) << 2) | $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
         else
            step(1'b0, '0, ($urandom_range(0, 3) != 0));
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      mark = pops;
      step(1'b1, 32'h102, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
      chk("mis_delivered", pops - mark, 1);
      step(1'b1, 32'h200, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
`endif

      chk("protocol", proto_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage for Ripple-32, directly upstream of the opcode decoder.
- Owns the PC and issues word fetches on a req/gnt/rvalid instruction-memory port.
- Buffers returned words in a small prefetch FIFO.
- Presents {instr, pc, fault} to decode over a valid/ready handshake; instr_opcode feeds the decoder's opcode input directly.
- Execute redirects the stream (branch/jump/trap) via redirect_valid/redirect_pc.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, prefetch FIFO entries; legal values 2 or 4

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
imem_err  input  1  bus error, qualified by imem_rvalid
redirect_valid  input  1  flush and restart at redirect_pc
redirect_pc  input  32  new fetch PC
instr_valid  output  1  decode entry available
instr_ready  input  1  decode accepts entry
instr  output  32  instruction word
instr_opcode  output  7  instr[6:0], to opcode decoder
instr_pc  output  32  address of instr
instr_fault  output  1  fetch bus error on this entry
instr_misaligned  output  1  misaligned redirect target (see Optional Feature)

Behaviour:
- Reset (async assert): imem_req=0, imem_addr=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=0, instr_fault=0, instr_misaligned=0, fetch_pc=RESET_PC, FSM=IDLE, discard=0, halted=0.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: imem_req=1; imem_addr and imem_req held stable until imem_gnt.
  - WAIT: granted; awaiting imem_rvalid. rvalid never arrives in the grant cycle.
- Issue condition: !halted and (FIFO count + outstanding) < BUF_DEPTH.
  - IDLE -> REQ when the issue condition holds.
  - REQ -> WAIT on gnt; fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
  - WAIT -> REQ on rvalid if the issue condition holds with this response counted, else -> IDLE.
  - Only one request is ever outstanding. Zero-wait memory (gnt same cycle, rvalid next) sustains 1 instr/cycle.
- Response handling:
  - On rvalid with discard=0, push {rdata, pc, imem_err}.
  - If imem_err=1: halted=1 and no further requests until redirect.
- Output:
  - instr_valid = !FIFO empty && !redirect_valid. Head fields are registered.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are both honoured. Push to a full FIFO cannot occur (issue condition).
  - Latency from rvalid to instr_valid is 1 cycle.
- Redirect (redirect_valid=1, single cycle):
  - Next cycle: FIFO empty, fetch_pc = {redirect_pc[31:2], 2'b00}, halted=0.
  - Any handshake in the redirect cycle is not a transfer.
  - In REQ (not yet granted): request stays up with the old address until gnt, then discard=1.
  - In WAIT, or gnt in the same cycle: discard=1.
  - A discarded response is dropped and clears discard. The new request then issues per the FSM.
  - Redirect in the same cycle as rvalid: that response is dropped.
  - Back-to-back redirects: the last one wins.
- instr_opcode is always instr[6:0]. When FIFO is empty, output fields hold their last values.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 issues no memory request.
  - Pushes one entry {instr=0, pc=redirect_pc unmasked, fault=0, misaligned=1}, then sets halted=1 until the next redirect.
  - Any outstanding response is discarded as usual.
- Undefined: redirect_pc[1:0] ignored (forced to 00); instr_misaligned tied 0.

Test Plan:
- Reset release with zero-wait memory returning addr^32'hA5A5_0000 -> first imem_addr=0x0; instr_valid rises 2 cycles after first gnt; then pc 0,4,8,... one per cycle with instr_ready=1.
- instr_ready=0 for 10 cycles -> imem_req drops once count=BUF_DEPTH; no entry lost or duplicated on resume.
- Redirect to 0x100 while in WAIT for addr 0x8 -> 0x8 response dropped; next delivered pc=0x100; no entry from 0x8 reaches decode.
- imem_err=1 on pc 0x10 -> entry pc=0x10 with instr_fault=1; imem_req stays 0 until redirect to 0x40, then fetch resumes at 0x40.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> one entry pc=0x102, instr_misaligned=1, no imem_req until the next redirect.
